mod_addsub_ctrl: RTL and testbench

- Initiator side of the multi-precision adder start/done handshake.
- Sequences one or two adder operations to compute modular addition (a+b mod M) or modular subtraction (a-b mod M) on 1024-bit operands.
- Sits between the Montgomery/exponentiation datapath and the 1027-bit adder; owns the adder's start/subtract/operand inputs.

---
 rtl/mod_addsub_ctrl_if.sv | 24 ++
 rtl/mod_addsub_ctrl.sv | 109 ++++++++++
 tb/tb_mod_addsub_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_addsub_ctrl_if.sv
// Request/response bundle between the exponentiation datapath (master) and the
// modular add/subtract sequencer (slave).
interface mod_addsub_ctrl_if #(
  parameter int unsigned N = 1024
) ();
  logic         start;
  logic         subtract;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;
  logic         busy;

  modport master (
    output start, subtract, in_a, in_b, in_m,
    input  result, done, busy
  );

  modport slave (
    input  start, subtract, in_a, in_b, in_m,
    output result, done, busy
  );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives a wide adder through one or two passes to
// produce (a+b) mod M or (a-b) mod M.
module mod_addsub_ctrl #(
  parameter int unsigned N  = 1024,
  parameter int unsigned AW = 1027
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mod_addsub_ctrl_if.slave      req,
  output logic                  add_start_o,
  output logic                  add_subtract_o,
  output logic [AW-1:0]         add_in_a_o,
  output logic [AW-1:0]         add_in_b_o,
  input  logic [AW:0]           add_result_i,
  input  logic                  add_done_i
);

  localparam int unsigned PadW = AW - N;

  typedef enum logic [2:0] {StIdle, StReq1, StWait1, StReq2, StWait2, StFin} state_e;

  state_e        state_q;
  logic          op_q;
  logic [N-1:0]  m_q;
  logic [N-1:0]  result_q;
  logic          done_q;
  logic          busy_q;
  logic          add_start_q;
  logic          add_subtract_q;
  logic [AW-1:0] add_in_a_q;
  logic [AW-1:0] add_in_b_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      op_q           <= 1'b0;
      m_q            <= '0;
      result_q       <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      add_start_q    <= 1'b0;
      add_subtract_q <= 1'b0;
      add_in_a_q     <= '0;
      add_in_b_q     <= '0;
    end else begin
      add_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Operands load straight into the adder-facing registers so add_start is
          // already high in the first REQ1 cycle.
          if (req.start) begin
            op_q           <= req.subtract;
            m_q            <= req.in_m;
            add_in_a_q     <= {{PadW{1'b0}}, req.in_a};
            add_in_b_q     <= {{PadW{1'b0}}, req.in_b};
            add_subtract_q <= req.subtract;
            add_start_q    <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= StReq1;
          end
        end
        StReq1: state_q <= StWait1;
        StWait1: begin
          if (add_done_i) begin
            if (op_q && !add_result_i[AW]) begin
              result_q <= add_result_i[N-1:0];
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StFin;
            end else begin
              // Add: trial-subtract M. Negative difference: add M back.
              add_in_a_q     <= add_result_i[AW-1:0];
              add_in_b_q     <= {{PadW{1'b0}}, m_q};
              add_subtract_q <= ~op_q;
              add_start_q    <= 1'b1;
              state_q        <= StReq2;
            end
          end
        end
        StReq2: state_q <= StWait2;
        StWait2: begin
          if (add_done_i) begin
            // add_in_a_q still holds r1, so a borrow on a+b-M selects it directly.
            if (!op_q && add_result_i[AW]) begin
              result_q <= add_in_a_q[N-1:0];
            end else begin
              result_q <= add_result_i[N-1:0];
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req.result     = result_q;
  assign req.done       = done_q;
  assign req.busy       = busy_q;
  assign add_start_o    = add_start_q;
  assign add_subtract_o = add_subtract_q;
  assign add_in_a_o     = add_in_a_q;
  assign add_in_b_o     = add_in_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a behavioural variable-latency adder.
module tb_mod_addsub_ctrl;

  localparam int unsigned N  = 1024;
  localparam int unsigned AW = 1027;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          add_start;
  logic          add_subtract;
  logic [AW-1:0] add_in_a;
  logic [AW-1:0] add_in_b;
  logic [AW:0]   add_result = '0;
  logic          add_done = 1'b0;

  mod_addsub_ctrl_if #(.N(N)) rq ();

  mod_addsub_ctrl #(.N(N), .AW(AW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req            (rq),
    .add_start_o    (add_start),
    .add_subtract_o (add_subtract),
    .add_in_a_o     (add_in_a),
    .add_in_b_o     (add_in_b),
    .add_result_i   (add_result),
    .add_done_i     (add_done)
  );

  always #5 clk = ~clk;

  // Adder model: result returns 'lat' cycles after the add_start cycle.
  int            lat = 1;
  int            n_starts = 0;
  int            viol = 0;
  int            cnt = 0;
  int            done_cnt = 0;
  logic          pending = 1'b0;
  logic          prev_start = 1'b0;
  logic          chk_en = 1'b0;
  logic          last_sub = 1'b0;
  logic          inject_done = 1'b0;
  logic [AW:0]   inject_val = '0;
  logic [AW:0]   res_hold = '0;
  logic [AW-1:0] hold_a = '0;
  logic [AW-1:0] hold_b = '0;
  logic          hold_s = 1'b0;
  logic [AW:0]   sum_c;

  assign sum_c = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                              : ({1'b0, add_in_a} + {1'b0, add_in_b});

  always @(posedge clk) begin
    add_done <= 1'b0;
    if (!rst_n) chk_en <= 1'b0;
    if (inject_done) begin
      add_done   <= 1'b1;
      add_result <= inject_val;
    end
    if (add_start === 1'b1) begin
      n_starts <= n_starts + 1;
      last_sub <= add_subtract;
      if (prev_start || pending) viol <= viol + 1;
      hold_a <= add_in_a;
      hold_b <= add_in_b;
      hold_s <= add_subtract;
      chk_en <= 1'b1;
      if (lat <= 1) begin
        add_done   <= 1'b1;
        add_result <= sum_c;
      end else begin
        pending  <= 1'b1;
        cnt      <= lat - 1;
        res_hold <= sum_c;
      end
    end else if (pending) begin
      if (chk_en && rst_n && (add_in_a !== hold_a || add_in_b !== hold_b ||
                              add_subtract !== hold_s)) viol <= viol + 1;
      if (cnt == 1) begin
        add_done   <= 1'b1;
        add_result <= res_hold;
        pending    <= 1'b0;
      end
      cnt <= cnt - 1;
    end
    prev_start <= (add_start === 1'b1);
  end

  always @(posedge clk) if (rq.done === 1'b1) done_cnt <= done_cnt + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk_w(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", tag, obs[N-1:N-64], obs[63:0],
             exp[N-1:N-64], exp[63:0]);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] m);
    @(negedge clk);
    rq.start = 1'b1; rq.subtract = sub; rq.in_a = a; rq.in_b = b; rq.in_m = m;
    @(negedge clk);
    rq.start = 1'b0;
  endtask

  task automatic wait_done(output logic got, output int cyc, output logic prev_ad);
    got = 1'b0; cyc = 1; prev_ad = 1'b0;
    while (cyc < 400 && rq.done !== 1'b1) begin
      prev_ad = add_done;
      @(negedge clk);
      cyc++;
    end
    got = (rq.done === 1'b1);
  endtask

  task automatic run_op(input string tag, input logic sub, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] m, input int latency,
                        input logic [N-1:0] exp_res, input int exp_starts,
                        input logic exp_last_sub, input int exp_cyc);
    int   s0, cyc;
    logic got, prev_ad;
    lat = latency;
    s0  = n_starts;
    pulse_start(sub, a, b, m);
    chk_i({tag, "_busy_hi"}, int'(rq.busy), 1);
    wait_done(got, cyc, prev_ad);
    chk_i({tag, "_done_seen"}, int'(got), 1);
    chk_w({tag, "_result"}, rq.result, exp_res);
    chk_i({tag, "_busy_at_done"}, int'(rq.busy), 0);
    chk_i({tag, "_done_after_add_done"}, int'(prev_ad), 1);
    chk_i({tag, "_add_starts"}, n_starts - s0, exp_starts);
    chk_i({tag, "_last_sub"}, int'(last_sub), int'(exp_last_sub));
    if (exp_cyc >= 0) chk_i({tag, "_latency"}, cyc, exp_cyc);
    @(negedge clk);
    chk_i({tag, "_done_one_cycle"}, int'(rq.done), 0);
  endtask

  initial begin
    logic [N-1:0] m13, big_m, big_a, big_exp;
    int           s0, d0, cyc, guard;
    logic         got, prev_ad;

    m13     = N'(13);
    big_m   = '1;
    big_a   = big_m - N'(1);
    big_exp = big_m - N'(2);

    rst_n = 1'b0;
    rq.start = 1'b0; rq.subtract = 1'b0; rq.in_a = '0; rq.in_b = '0; rq.in_m = '0;
    repeat (3) @(negedge clk);
    chk_w("rst_result", rq.result, '0);
    chk_i("rst_done", int'(rq.done), 0);
    chk_i("rst_busy", int'(rq.busy), 0);
    chk_i("rst_add_start", int'(add_start), 0);
    chk_i("rst_add_sub", int'(add_subtract), 0);
    chk_w("rst_add_in_a", add_in_a[N-1:0], '0);
    chk_w("rst_add_in_b", add_in_b[N-1:0], '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("add_7_9",    1'b0, N'(7), N'(9), m13, 1, N'(3), 2, 1'b1, -1);
    run_op("add_2_3",    1'b0, N'(2), N'(3), m13, 3, N'(5), 2, 1'b1, -1);
    run_op("add_eq_m",   1'b0, N'(6), N'(7), m13, 2, N'(0), 2, 1'b1, -1);
    run_op("sub_9_3",    1'b1, N'(9), N'(3), m13, 1, N'(6), 1, 1'b1, 3);
    run_op("sub_9_3_l4", 1'b1, N'(9), N'(3), m13, 4, N'(6), 1, 1'b1, 6);
    run_op("sub_3_9",    1'b1, N'(3), N'(9), m13, 2, N'(7), 2, 1'b0, -1);
    run_op("sub_eq",     1'b1, N'(5), N'(5), m13, 1, N'(0), 1, 1'b1, 3);
    run_op("add_big",    1'b0, big_a, big_a, big_m, 1, big_exp, 2, 1'b1, -1);

    // Spurious add_done while idle.
    d0 = done_cnt;
    @(negedge clk);
    inject_val = {1'b0, {AW{1'b1}}};
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_w("spurious_result", rq.result, big_exp);
    chk_i("spurious_busy", int'(rq.busy), 0);
    chk_i("spurious_done", done_cnt - d0, 0);

    // Start while busy and start during the done cycle are both dropped.
    lat = 4;
    s0  = n_starts;
    pulse_start(1'b0, N'(7), N'(9), m13);
    @(negedge clk);
    rq.start = 1'b1; rq.subtract = 1'b1; rq.in_a = N'(1); rq.in_b = N'(1);
    @(negedge clk);
    rq.start = 1'b0;
    wait_done(got, cyc, prev_ad);
    chk_i("busy_start_done", int'(got), 1);
    chk_w("busy_start_result", rq.result, N'(3));
    chk_i("busy_start_starts", n_starts - s0, 2);
    rq.start = 1'b1; rq.subtract = 1'b1; rq.in_a = N'(4); rq.in_b = N'(2);
    @(negedge clk);
    rq.start = 1'b0;
    chk_i("fin_start_busy", int'(rq.busy), 0);
    repeat (4) @(negedge clk);
    chk_i("fin_start_starts", n_starts - s0, 2);
    chk_w("fin_start_result", rq.result, N'(3));

    // Reset asserted in WAIT2, with the adder's answer arriving after release.
    lat = 8;
    s0  = n_starts;
    pulse_start(1'b0, N'(7), N'(9), m13);
    guard = 0;
    while (n_starts != s0 + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk_i("midrst_second_req", n_starts - s0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_i("midrst_busy", int'(rq.busy), 0);
    chk_w("midrst_result", rq.result, '0);
    chk_w("midrst_add_in_a", add_in_a[N-1:0], '0);
    chk_i("midrst_add_sub", int'(add_subtract), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (pending && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk_i("late_done_busy", int'(rq.busy), 0);
    chk_i("late_done_no_done", done_cnt - d0, 0);
    chk_w("late_done_result", rq.result, '0);

    run_op("post_rst_sub", 1'b1, N'(9), N'(3), m13, 1, N'(6), 1, 1'b1, 3);
    run_op("post_rst_add", 1'b0, N'(12), N'(12), m13, 2, N'(11), 2, 1'b1, -1);

    chk_i("adder_protocol", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
